// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch initiator: owns fetch PC, reads RAM, loads IR
module ifu_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4,
    parameter int                TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              ir_load,
    output logic [31:0]       ir_data,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CAP,
        S_LOAD,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [7:0]        timer_q, timer_d;
    logic              squash_q, squash_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              ir_load_q, ir_load_d;
    logic [31:0]       ir_data_q, ir_data_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              busy_q, busy_d;
    logic              fetch_err_q, fetch_err_d;

    // Next-state and next-output computation; every output is registered from here.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        timer_d     = timer_q;
        squash_d    = squash_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        ir_load_d   = 1'b0;
        ir_data_d   = ir_data_q;
        pc_d        = pc_q;
        fetch_err_d = fetch_err_q;

        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
                if (start) begin
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = redirect ? redirect_pc : fetch_pc_q;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    // A redirect coinciding with the grant cannot retract the
                    // accepted read, so its data must be thrown away later.
                    state_d   = S_WAIT;
                    mem_req_d = 1'b0;
                    timer_d   = '0;
                    squash_d  = redirect;
                    if (redirect) begin
                        fetch_pc_d = redirect_pc;
                    end
                end else if (redirect) begin
                    mem_addr_d = redirect_pc;
                    fetch_pc_d = redirect_pc;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    squash_d   = 1'b1;
                end
                if (mem_rvalid) begin
                    if (squash_q || redirect) begin
                        state_d    = S_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = redirect ? redirect_pc : fetch_pc_q;
                        squash_d   = 1'b0;
                    end else begin
                        ir_data_d = mem_rdata;
                        state_d   = S_CAP;
                    end
                end else if (timer_q == 8'(TIMEOUT)) begin
                    state_d     = S_ERR;
                    fetch_err_d = 1'b1;
                    squash_d    = 1'b0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_CAP: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = redirect_pc;
                end else begin
                    // pc and ir_load change together so IR sees a matching pair.
                    state_d    = S_LOAD;
                    ir_load_d  = 1'b1;
                    pc_d       = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
            end
            S_ERR: begin
                mem_req_d = 1'b0;
                if (redirect) begin
                    fetch_err_d = 1'b0;
                    fetch_pc_d  = redirect_pc;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            timer_q     <= '0;
            squash_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= RESET_PC;
            ir_load_q   <= 1'b0;
            ir_data_q   <= '0;
            pc_q        <= RESET_PC;
            busy_q      <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            timer_q     <= timer_d;
            squash_q    <= squash_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            ir_load_q   <= ir_load_d;
            ir_data_q   <= ir_data_d;
            pc_q        <= pc_d;
            busy_q      <= busy_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign ir_load   = ir_load_q;
    assign ir_data   = ir_data_q;
    assign pc        = pc_q;
    assign busy      = busy_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch with an ir_load scoreboard
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ir_load;
    logic [31:0] ir_data;
    logic [31:0] pc;
    logic        busy;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];

    ifu_fetch #(
        .ADDR_W  (32),
        .RESET_PC(32'h0),
        .PC_STEP (4),
        .TIMEOUT (255)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ir_load    (ir_load),
        .ir_data    (ir_data),
        .pc         (pc),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every ir_load pulse must match the oldest expected word.
    always @(posedge clk) begin
        #1;
        if (rst_n && ir_load) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_load: ir_data=%h pc=%h, no load expected", ir_data, pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (ir_data !== e.data) begin
                    errors++;
                    $display("FAIL sb_ir_data: got %h expected %h", ir_data, e.data);
                end
                checks++;
                if (pc !== e.addr) begin
                    errors++;
                    $display("FAIL sb_pc: got %h expected %h", pc, e.addr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Full fetch at exp_addr with gnt held off for gnt_wait cycles.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] rdata, input int gnt_wait);
        int n;
        start = 1'b1;
        tick();
        start    = 1'b0;
        redirect = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
            errors++;
            $display("FAIL fetch_req: mem_req=%b mem_addr=%h expected 1/%h", mem_req, mem_addr, exp_addr);
        end
        for (int i = 0; i < gnt_wait; i++) begin
            tick();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr || ir_load !== 1'b0) begin
                errors++;
                $display("FAIL gnt_hold: mem_req=%b mem_addr=%h ir_load=%b expected 1/%h/0", mem_req, mem_addr, ir_load, exp_addr);
            end
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL after_gnt: mem_req=%b busy=%b expected 0/1", mem_req, busy);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        sb.push_back('{data: rdata, addr: exp_addr});
        tick();
        mem_rvalid = 1'b0;
        n = 0;
        while (ir_load !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (ir_load !== 1'b1) begin
            errors++;
            $display("FAIL fetch_timeout: ir_load never seen, got %b expected 1", ir_load);
        end
        tick();
        checks++;
        if (ir_load !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_pulse: ir_load=%b busy=%b expected 0/0", ir_load, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; redirect = 1'b0; redirect_pc = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #12;
        checks++;
        if ({mem_req, ir_load, busy, fetch_err} !== 4'b0000 || mem_addr !== 32'h0 || ir_data !== 32'h0 || pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: req=%b load=%b busy=%b err=%b addr=%h ir=%h pc=%h expected all 0",
                     mem_req, ir_load, busy, fetch_err, mem_addr, ir_data, pc);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n;
        start = 1'b1;
        tick();
        n = 1;
        start   = 1'b0;
        mem_gnt = 1'b1;
        tick();
        n++;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0040_0093;
        sb.push_back('{data: 32'h0040_0093, addr: 32'h0});
        tick();
        n++;
        mem_rvalid = 1'b0;
        while (ir_load !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        checks++;
        if (n + 1 != 5) begin
            errors++;
            $display("FAIL basic_latency: ir_load in cycle %0d expected 5", n + 1);
        end
        tick();
        do_fetch(32'h4, 32'h0081_0113, 0);
    endtask

    task automatic test_gnt_stall();
        apply_reset();
        do_fetch(32'h0, 32'h1111_2222, 3);
    endtask

    task automatic test_squash();
        start = 1'b1;
        tick();
        start   = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || ir_load !== 1'b0 || ir_data !== 32'h1111_2222) begin
            errors++;
            $display("FAIL squash: req=%b addr=%h load=%b ir=%h expected 1/100/0/11112222", mem_req, mem_addr, ir_load, ir_data);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0010_0513;
        sb.push_back('{data: 32'h0010_0513, addr: 32'h100});
        tick();
        mem_rvalid = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL squash_done: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_timeout();
        int n;
        start = 1'b1;
        tick();
        start   = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        n = 0;
        while (fetch_err !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (fetch_err !== 1'b1 || busy !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err=%b busy=%b req=%b after %0d cycles expected 1/1/0", fetch_err, busy, mem_req, n);
        end
        checks++;
        if (n < 250 || n > 260) begin
            errors++;
            $display("FAIL timeout_len: %0d cycles expected about 256", n);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL err_start_ignored: req=%b err=%b expected 0/1", mem_req, fetch_err);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        checks++;
        if (fetch_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b busy=%b expected 0/0", fetch_err, busy);
        end
        do_fetch(32'h20, 32'h0200_0093, 1);
    endtask

    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        do_fetch(32'hFFFF_FFFC, 32'hCAFE_0013, 0);
        do_fetch(32'h0, 32'h0000_0013, 0);
    endtask

    task automatic test_reset_mid_fetch();
        start = 1'b1;
        tick();
        start   = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, ir_load, busy, fetch_err} !== 4'b0000 || mem_addr !== 32'h0 || ir_data !== 32'h0 || pc !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: req=%b load=%b busy=%b err=%b addr=%h ir=%h pc=%h expected all 0",
                     mem_req, ir_load, busy, fetch_err, mem_addr, ir_data, pc);
        end
        tick();
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        tick();
        mem_rvalid = 1'b0;
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0 || ir_data !== 32'h0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL late_rvalid: busy=%b ir=%h req=%b expected 0/0/0", busy, ir_data, mem_req);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gnt_stall();
        test_squash();
        test_timeout();
        test_wrap();
        test_reset_mid_fetch();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected loads missing, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
